// File: rtl/psram_pkg.sv
// Shared FSM states, PSRAM pin command encodings and access-time helper
// for psram_controller.
`timescale 1ns/1ps
package psram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RECOVER,
        ACK
    } state_e;

    // Control pin triple ordered {cen, wen, oen}.
    typedef logic [2:0] psram_cmd_t;
    localparam psram_cmd_t CMD_STANDBY = 3'b111;
    localparam psram_cmd_t CMD_READ    = 3'b010;
    localparam psram_cmd_t CMD_WRITE   = 3'b001;

    // One cycle beyond ceil(tAA/clk) so the read sample lands strictly after tAA.
    function automatic int calc_access_cycles(input int t_access_ns, input int clk_period_ns);
        return (t_access_ns + clk_period_ns - 1) / clk_period_ns + 1;
    endfunction

endpackage

// File: rtl/psram_controller.sv
// 32-bit bus to async 16-bit PSRAM bridge: one or two halfword cycles per request.
// Optional macro PSRAM_ERR_EN adds err_o, pulsed instead of ack_o for sel_i == 0.
`timescale 1ns/1ps
module psram_controller
    import psram_pkg::*;
#(
    parameter int CLK_PERIOD_NS    = 10,
    parameter int T_ACCESS_NS      = 70,
    parameter int T_RECOVER_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [22:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
`ifdef PSRAM_ERR_EN
    output logic        err_o,
`endif
    output logic        psram_cen,
    output logic        psram_wen,
    output logic        psram_oen,
    output logic        psram_lbn,
    output logic        psram_ubn,
    output logic [21:0] psram_a,
    inout  wire  [15:0] psram_d
);

    localparam int ACCESS_CYCLES = calc_access_cycles(T_ACCESS_NS, CLK_PERIOD_NS);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(T_RECOVER_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [20:0]       waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              hw_q, hw_d;
    logic              pend_q, pend_d;
    logic              abort_q, abort_d;
`ifdef PSRAM_ERR_EN
    logic              nosel_q, nosel_d;
`endif

    logic [1:0]  lane_sel;
    logic [15:0] lane_wdata;
    logic [15:0] lane_mask;
    logic        d_oe;
    logic        unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign lane_sel    = hw_q ? sel_q[3:2] : sel_q[1:0];
    assign lane_wdata  = hw_q ? wdata_q[31:16] : wdata_q[15:0];
    assign lane_mask   = {{8{lane_sel[1]}}, {8{lane_sel[0]}}};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            hw_q    <= 1'b0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef PSRAM_ERR_EN
            nosel_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            hw_q    <= hw_d;
            pend_q  <= pend_d;
            abort_q <= abort_d;
`ifdef PSRAM_ERR_EN
            nosel_q <= nosel_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        hw_d    = hw_q;
        pend_d  = pend_q;
        abort_d = abort_q;
`ifdef PSRAM_ERR_EN
        nosel_d = nosel_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    we_d    = we_i;
                    sel_d   = sel_i;
                    waddr_d = addr_i[22:2];
                    wdata_d = data_i;
                    rbuf_d  = '0;
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    // Start on the lower halfword unless it has no enabled bytes.
                    hw_d    = ~(|sel_i[1:0]);
                    pend_d  = (|sel_i[1:0]) & (|sel_i[3:2]);
                    state_d = (sel_i == 4'h0) ? ACK : SETUP;
`ifdef PSRAM_ERR_EN
                    nosel_d = (sel_i == 4'h0);
`endif
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == ACC_LAST) begin
                    cnt_d   = '0;
                    state_d = RECOVER;
                    if (!we_q) begin
                        if (hw_q) rbuf_d[31:16] = psram_d & lane_mask;
                        else      rbuf_d[15:0]  = psram_d & lane_mask;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    cnt_d = '0;
                    if (abort_q || !cyc_i) begin
                        state_d = IDLE;
                    end else if (pend_q) begin
                        hw_d    = 1'b1;
                        pend_d  = 1'b0;
                        state_d = SETUP;
                    end else begin
                        state_d = ACK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A dropped cycle lets the running access finish, then abandons the rest.
        if ((state_q == SETUP || state_q == ACCESS || state_q == RECOVER) && !cyc_i)
            abort_d = 1'b1;
    end

    always_comb begin
        {psram_cen, psram_wen, psram_oen} = CMD_STANDBY;
        psram_lbn = 1'b1;
        psram_ubn = 1'b1;
        d_oe      = 1'b0;
        ack_o     = 1'b0;
        data_o    = '0;
`ifdef PSRAM_ERR_EN
        err_o     = 1'b0;
`endif
        unique case (state_q)
            SETUP: begin
                psram_wen = ~we_q;
                psram_lbn = ~lane_sel[0];
                psram_ubn = ~lane_sel[1];
            end
            ACCESS: begin
                {psram_cen, psram_wen, psram_oen} = we_q ? CMD_WRITE : CMD_READ;
                psram_lbn = ~lane_sel[0];
                psram_ubn = ~lane_sel[1];
                d_oe      = we_q;
            end
            ACK: begin
`ifdef PSRAM_ERR_EN
                ack_o = ~nosel_q;
                err_o = nosel_q;
`else
                ack_o = 1'b1;
`endif
                data_o = rbuf_q;
            end
            default: ;
        endcase
    end

    assign psram_a = {waddr_q, hw_q};
    assign psram_d = d_oe ? lane_wdata : 16'hzzzz;

endmodule

// File: doc/psram_controller.md
Name: psram_controller

Overview:
- Host-side initiator for the IS66WVE4M16EBLL-70BLI asynchronous PSRAM (4M x 16).
- Converts a single-clock, Wishbone-style 32-bit bus request into one or two asynchronous 16-bit PSRAM read or write cycles.
- Owns all PSRAM control, address and data pins.
- Sits between the CPU memory arbiter and the PSRAM pins; the PSRAM simulation model is its counterpart in benches.

Parameters:
- CLK_PERIOD_NS, 10: period of clk_i in ns.
- T_ACCESS_NS, 70: PSRAM access time in ns.
- T_RECOVER_CYCLES, 1: minimum cycles CE# stays high between accesses (≥1).

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  4  byte enables; sel_i[0] selects data[7:0].
- addr_i  in  23  byte address; [1:0] ignored (word aligned).
- data_i  in  32  write data.
- data_o  out  32  read data; valid while ack_o is high.
- ack_o  out  1  one-cycle completion pulse.
- psram_cen  out  1  CE#.
- psram_wen  out  1  WE#.
- psram_oen  out  1  OE#.
- psram_lbn  out  1  LB#.
- psram_ubn  out  1  UB#.
- psram_a  out  22  halfword address.
- psram_d  inout  16  data bus.

Behaviour:
- Reset values: psram_cen/wen/oen/lbn/ubn = 1, psram_a = 0, psram_d = Z, ack_o = 0, data_o = 0, state IDLE.
- ACCESS_CYCLES = ceil(T_ACCESS_NS / CLK_PERIOD_NS) + 1 (8 at defaults). This guarantees data is sampled strictly after tAA.
- Halfword 0: psram_a = {addr_i[22:2], 0}, lane data[15:0], lbn = ~sel[0], ubn = ~sel[1].
- Halfword 1: psram_a = {addr_i[22:2], 1}, lane data[31:16], lbn = ~sel[2], ubn = ~sel[3].
- A halfword whose two sel bits are both 0 is skipped entirely; no PSRAM cycle is issued for it.
- States and transitions:
  - IDLE: accepts a request when cyc_i & stb_i. It latches we, sel, addr and data, then goes to SETUP on the first needed halfword. If sel_i == 0, it goes directly to ACK.
  - SETUP (1 cycle): drive psram_a, lbn, ubn and wen = ~we with cen = 1 and oen = 1. psram_d stays Z.
  - ACCESS (ACCESS_CYCLES cycles): cen = 0.
    - Write: psram_d driven with the lane data for the whole state.
    - Read: oen = 0, psram_d = Z, and the lane is captured into the data buffer on the last ACCESS cycle. Unselected bytes read as 0.
  - RECOVER (T_RECOVER_CYCLES cycles): cen/wen/oen/lbn/ubn = 1 and psram_d = Z. Then go to SETUP if halfword 1 is still pending, else to ACK.
  - ACK (1 cycle): ack_o = 1 and data_o = buffer (0 for writes). Then IDLE. A new request can be accepted only in IDLE, the cycle after ACK.
- psram_d is driven only when cen = 0 and wen = 0; it is never driven in SETUP or RECOVER.
- Latency at defaults, counted from the accepting IDLE cycle (cycle 0):
  - One halfword: SETUP at cycle 1, ACCESS cycles 2–9, RECOVER cycle 10, ack_o at cycle 11.
  - Both halfwords: ack_o at cycle 21.
- cyc_i deasserted mid-transaction: the current PSRAM access runs to the end of RECOVER (a DRAM cycle is never truncated). The remaining halfword is dropped, no ack is issued, and the state returns to IDLE.
- stb_i/addr_i changes after acceptance are ignored because the request is latched.
- Asynchronous reset at any point immediately forces all reset values, including releasing psram_d and raising cen.

Optional Feature:
- Macro: PSRAM_ERR_EN.
- Defined: adds output port err_o (1 bit, reset 0). A request with sel_i == 0 pulses err_o for one cycle (ack_o stays 0), one cycle after acceptance.
- Not defined: no err_o port; a sel_i == 0 request pulses ack_o with data_o = 0, one cycle after acceptance. In both cases no PSRAM pin toggles.

Decomposition:
- psram_pkg holds:
  - state enum: IDLE, SETUP, ACCESS, RECOVER, ACK;
  - PSRAM command encodings {cen, wen, oen}: STANDBY 3'b111, READ 3'b010, WRITE 3'b001;
  - a constant function computing ACCESS_CYCLES from the two timing parameters.
- No sub-module: the timing counter and halfword sequencer stay inline in psram_controller.

Test Plan:
- Write 32'hDEADBEEF, sel 4'hF, addr 23'h000010, then read the same address → model holds [0x000008] = BEEF and [0x000009] = DEAD; read data_o = DEADBEEF; ack at cycles 21 and 21.
- Read with sel 4'b0100 at addr 23'h000020 after a full write of 32'h11223344 → a single PSRAM cycle with psram_a = 0x000011, lbn = 0, ubn = 1; data_o = 32'h00220000; ack at cycle 11.
- Write with sel 4'b0011 → exactly one CE# falling edge, psram_d driven only while cen = 0; the other halfword in the model is unchanged.
- Request with sel 4'h0 → no CE# edge; ack_o pulse (err_o pulse with PSRAM_ERR_EN) one cycle after acceptance.
- Drop cyc_i during the ACCESS of halfword 0 of a full-word write → halfword 0 still written, halfword 1 untouched, no ack, IDLE afterwards.
- Assert rst_n_i low in mid-ACCESS → cen = 1 and psram_d = Z in the same timestep; a following full-word read completes normally with ack at cycle 21.
